// File: rtl/onchip_mem_pattern_master.sv
// Avalon-MM memory self-test master: writes word i = seed + i over a region,
// reads the region back one word at a time and reports pass/fail, error count
// and the byte address of the first mismatching word.
module onchip_mem_pattern_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 13
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [31:0]       seed,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  typedef enum logic [2:0] {StIdle, StWrite, StRdReq, StRdWait, StFinish} state_e;

  state_e            state;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  idx_q;
  logic [31:0]       seed_q;
  logic              abort_q;

  logic              last_word;
  logic              abort_now;
  logic [31:0]       exp_data;

  // Word-level bookkeeping shared by the write and read phases.
  always_comb begin
    last_word = (idx_q == count_q - CNT_W'(1));
    abort_now = abort_q | abort;
    exp_data  = seed_q + 32'(idx_q);
  end

  // Full-word transfers only; lanes are enabled whenever a command is up.
  assign avm_byteenable = {4{avm_read | avm_write}};

  // Control FSM with registered bus and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= StIdle;
      base_q         <= '0;
      count_q        <= '0;
      idx_q          <= '0;
      seed_q         <= '0;
      abort_q        <= 1'b0;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      done <= 1'b0;
      // Abort is sticky for the rest of the run; only honoured at transfer boundaries.
      if (busy && abort) abort_q <= 1'b1;

      case (state)
        StIdle: begin
          if (start) begin
            base_q         <= {base_addr[ADDR_W-1:2], 2'b00};
            count_q        <= word_count;
            seed_q         <= seed;
            idx_q          <= '0;
            abort_q        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            if (word_count == '0) begin
              state <= StFinish;
            end else begin
              state         <= StWrite;
              avm_write     <= 1'b1;
              avm_address   <= {base_addr[ADDR_W-1:2], 2'b00};
              avm_writedata <= seed;
            end
          end
        end

        StWrite: begin
          if (!avm_waitrequest) begin
            if (last_word || abort_now) begin
              avm_write <= 1'b0;
              idx_q     <= '0;
              if (abort_now) begin
                state <= StFinish;
              end else begin
                state       <= StRdReq;
                avm_read    <= 1'b1;
                avm_address <= base_q;
              end
            end else begin
              idx_q         <= idx_q + CNT_W'(1);
              avm_address   <= avm_address + ADDR_W'(4);
              avm_writedata <= avm_writedata + 32'd1;
            end
          end
        end

        StRdReq: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= StRdWait;
          end
        end

        StRdWait: begin
          if (avm_readdatavalid) begin
            if (avm_readdata != exp_data) begin
              if (err_count != '1) err_count <= err_count + CNT_W'(1);
              // avm_address still holds the address of the word just read.
              if (err_count == '0) first_err_addr <= avm_address;
            end
            if (last_word || abort_now) begin
              state <= StFinish;
            end else begin
              idx_q       <= idx_q + CNT_W'(1);
              avm_read    <= 1'b1;
              avm_address <= avm_address + ADDR_W'(4);
              state       <= StRdReq;
            end
          end
        end

        StFinish: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= (err_count == '0) && !abort_q;
          state <= StIdle;
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_onchip_mem_pattern_master.sv
// Bench for onchip_mem_pattern_master: a negedge-driven Avalon slave model with
// programmable stalls and optional bit corruption, plus a scoreboard of
// expected write/read transfers filled when each run is kicked off.
module tb_onchip_mem_pattern_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] base_addr = '0;
  logic [12:0] word_count = '0;
  logic [31:0] seed = '0;
  logic [31:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        busy;
  logic        done;
  logic        pass;
  logic [12:0] err_count;
  logic [31:0] first_err_addr;

  onchip_mem_pattern_master #(.ADDR_W(32), .CNT_W(13)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .abort            (abort),
    .base_addr        (base_addr),
    .word_count       (word_count),
    .seed             (seed),
    .avm_address      (avm_address),
    .avm_byteenable   (avm_byteenable),
    .avm_read         (avm_read),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_count        (err_count),
    .first_err_addr   (first_err_addr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and slave-model state.
  logic [63:0] exp_wr_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] mem [0:63];
  logic [31:0] corrupt_addr = 32'hFFFF_FFFF;
  int          stall_wr = -1;
  int          stall_rd = -1;
  int          stall_n = 0;
  int          stall_left = 0;
  int          wr_ord = 0;
  int          rd_ord = 0;
  int          n_cmd = 0;
  int          cyc = 0;
  int          first_wr_cyc = 0;
  int          last_wr_cyc = 0;
  logic        held = 1'b0;
  logic [69:0] held_cmd;
  logic        rd_pending = 1'b0;
  logic [31:0] rd_data;

  // Slave model: decides waitrequest for the command the next posedge will
  // see, retires accepted transfers against the scoreboard, and returns read
  // data one cycle after acceptance.
  always @(negedge clk) begin
    logic [63:0] e;
    logic [31:0] a;
    cyc++;
    avm_readdatavalid = 1'b0;
    if (rd_pending) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = rd_data;
      rd_pending        = 1'b0;
    end
    if (reset_n && (avm_write || avm_read)) begin
      if (!held) begin
        held     = 1'b1;
        held_cmd = {avm_byteenable, avm_write, avm_read, avm_address, avm_writedata};
        if (avm_write && wr_ord == stall_wr) stall_left = stall_n;
        if (avm_read && rd_ord == stall_rd) stall_left = stall_n;
      end else begin
        check("cmd_stable", {avm_byteenable, avm_write, avm_read, avm_address, avm_writedata},
              held_cmd);
      end
      if (stall_left > 0) begin
        avm_waitrequest = 1'b1;
        stall_left--;
      end else begin
        avm_waitrequest = 1'b0;
        held = 1'b0;
        n_cmd++;
        if (avm_write) begin
          if (wr_ord == 0) first_wr_cyc = cyc;
          last_wr_cyc = cyc;
          wr_ord++;
          check("wr_expected", (exp_wr_q.size() != 0), 1);
          if (exp_wr_q.size() != 0) begin
            e = exp_wr_q.pop_front();
            check("wr_xfer", {avm_byteenable, avm_address, avm_writedata}, {4'hF, e});
          end
          mem[avm_address[7:2]] = avm_writedata;
        end else begin
          rd_ord++;
          check("rd_expected", (exp_rd_q.size() != 0), 1);
          if (exp_rd_q.size() != 0) begin
            a = exp_rd_q.pop_front();
            check("rd_xfer", {avm_byteenable, avm_address}, {4'hF, a});
          end
          rd_data    = mem[avm_address[7:2]] ^ {31'd0, (avm_address == corrupt_addr)};
          rd_pending = 1'b1;
        end
      end
    end else begin
      avm_waitrequest = 1'b0;
      held = 1'b0;
    end
  end

  // Load the scoreboard and pulse start; returns at the first negedge after start.
  task automatic kick(input logic [31:0] b, input logic [12:0] n, input logic [31:0] s,
                      input int n_reads);
    for (int i = 0; i < int'(n); i++) exp_wr_q.push_back({b + 32'(4 * i), s + 32'(i)});
    for (int i = 0; i < n_reads; i++) exp_rd_q.push_back(b + 32'(4 * i));
    @(negedge clk);
    wr_ord = 0;
    rd_ord = 0;
    base_addr  = b;
    word_count = n;
    seed       = s;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for done; lat counts cycles since start was driven.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    check("done_seen", done, 1);
    check("busy_at_done", busy, 0);
  endtask

  task automatic check_result(input string tag, input logic p, input logic [12:0] ec,
                              input logic [31:0] fa);
    check({tag, "_pass"}, pass, p);
    check({tag, "_err_count"}, err_count, ec);
    check({tag, "_first_err"}, first_err_addr, fa);
    check({tag, "_wr_q_empty"}, exp_wr_q.size(), 0);
    check({tag, "_rd_q_empty"}, exp_rd_q.size(), 0);
  endtask

  initial begin
    int lat1;
    int lat;
    int k;
    int cmd0;

    for (int i = 0; i < 64; i++) mem[i] = '0;

    // Reset state.
    #12;
    check("rst_bus", {avm_read, avm_write, avm_address, avm_writedata}, '0);
    check("rst_status", {busy, done, pass, err_count, first_err_addr}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: clean back-to-back run.
    kick(32'h0, 13'd4, 32'h1000, 4);
    check("t1_first_write", {avm_write, avm_address, avm_writedata}, {1'b1, 32'h0, 32'h1000});
    check("t1_busy", busy, 1);
    wait_done(lat1);
    check_result("t1", 1'b1, 13'd0, 32'h0);
    check("t1_back_to_back", last_wr_cyc - first_wr_cyc, 3);
    @(negedge clk);
    check("t1_done_pulse", done, 0);

    // 2: word at 0x8 corrupted on readback.
    corrupt_addr = 32'h8;
    kick(32'h0, 13'd4, 32'h1000, 4);
    wait_done(lat);
    check_result("t2", 1'b0, 13'd1, 32'h8);
    corrupt_addr = 32'hFFFF_FFFF;

    // 3: three stall cycles on the 2nd write and the 1st read.
    stall_wr = 1;
    stall_rd = 0;
    stall_n  = 3;
    kick(32'h0, 13'd4, 32'h1000, 4);
    wait_done(lat);
    check_result("t3", 1'b1, 13'd0, 32'h0);
    check("t3_latency", lat, lat1 + 6);
    stall_wr = -1;
    stall_rd = -1;

    // 4: zero-length run: no bus traffic, done two cycles after start.
    cmd0 = n_cmd;
    kick(32'h0, 13'd0, 32'h1234, 0);
    check("t4_no_cmd_early", {avm_read, avm_write}, 2'b00);
    wait_done(lat);
    check("t4_latency", lat, 2);
    check_result("t4", 1'b1, 13'd0, 32'h0);
    check("t4_no_traffic", n_cmd - cmd0, 0);

    // 5: abort during a stalled read: that read completes, nothing follows.
    stall_rd = 0;
    stall_n  = 3;
    kick(32'h20, 13'd4, 32'hA0, 1);
    k = 0;
    while (!avm_read && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("t5_read_seen", avm_read, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_read_held", {avm_read, avm_address}, {1'b1, 32'h20});
    wait_done(lat);
    repeat (10) @(negedge clk);
    check_result("t5", 1'b0, 13'd0, 32'h0);
    check("t5_read_count", rd_ord, 1);
    check("t5_bus_idle", {avm_read, avm_write}, 2'b00);
    stall_rd = -1;

    // 6: asynchronous reset in the middle of the write phase.
    kick(32'h80, 13'd8, 32'h55, 0);
    @(negedge clk);
    check("t6_writing", avm_write, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_bus", {avm_read, avm_write, busy}, 3'b000);
    check("t6_async_cnt", {done, pass, err_count, first_err_addr}, '0);
    exp_wr_q.delete();
    exp_rd_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    kick(32'h40, 13'd2, 32'hDEAD_BEEF, 2);
    wait_done(lat);
    check_result("t6", 1'b1, 13'd0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
